// File: rtl/hbuf_pg_arb_pkg.sv
// Shared types and defaults for the hit-buffer page-port arbiter.
// Optional per-requester grant counters are enabled by HBUF_PG_ARB_GNT_CNT_EN.
package hbuf_pg_arb_pkg;

  localparam int PG_ADDR_W = 28;
  localparam int N_REQ_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_REL  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/hbuf_rr_pick.sv
// Combinational round-robin pick: first set request bit after 'last', wrapping.
module hbuf_rr_pick
  import hbuf_pg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest set bit after 'last' wins.
  always_comb begin
    winner = last;
    valid  = |req;
    cand   = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(last) + off) % N_REQ);
      if (req[cand]) winner = cand;
    end
  end

endmodule

// File: rtl/hbuf_pg_arb.sv
// Round-robin arbiter sharing one DDR3 page-transfer port among N_REQ hit buffers.
// Define HBUF_PG_ARB_GNT_CNT_EN to add per-requester 16-bit grant counters (gnt_cnt).
//
// state  | meaning
// S_IDLE | no grant; pick next requester round-robin
// S_REQ  | pg_req to DDR3 held, winner's addr/optype frozen
// S_REL  | ack_out high until requester and DDR3 both release
module hbuf_pg_arb
  import hbuf_pg_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = PG_ADDR_W,
  parameter int IDX_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_in,
  input  logic [N_REQ-1:0]        optype_in,
  input  logic [N_REQ*ADDR_W-1:0] addr_in,
  output logic [N_REQ-1:0]        ack_out,
  output logic                    pg_req,
  output logic                    pg_optype,
  output logic [ADDR_W-1:0]       pg_addr,
  input  logic                    pg_ack,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_idx
`ifdef HBUF_PG_ARB_GNT_CNT_EN
  ,
  output logic [N_REQ*16-1:0]     gnt_cnt
`endif
);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  ack_d;
  logic              pg_req_d, opt_d, busy_d;
  logic [ADDR_W-1:0] addr_d;
  logic [IDX_W-1:0]  grant_d, pick_idx;
  logic              pick_vld;

  hbuf_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (req_in),
    .last   (grant_idx),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ack_out   <= '0;
      pg_req    <= 1'b0;
      pg_optype <= 1'b0;
      pg_addr   <= '0;
      busy      <= 1'b0;
      grant_idx <= IDX_W'(N_REQ - 1);
    end else begin
      state_q   <= state_d;
      ack_out   <= ack_d;
      pg_req    <= pg_req_d;
      pg_optype <= opt_d;
      pg_addr   <= addr_d;
      busy      <= busy_d;
      grant_idx <= grant_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_out;
    pg_req_d = pg_req;
    opt_d    = pg_optype;
    addr_d   = pg_addr;
    grant_d  = grant_idx;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d  = pick_idx;
          opt_d    = optype_in[pick_idx];
          for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) addr_d = addr_in[i*ADDR_W +: ADDR_W];
          end
          pg_req_d = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        // A stale pg_ack still high on entry counts as the acknowledge.
        if (pg_ack) begin
          pg_req_d         = 1'b0;
          ack_d            = '0;
          ack_d[grant_idx] = 1'b1;
          state_d          = S_REL;
        end
      end
      S_REL: begin
        if (!req_in[grant_idx] && !pg_ack) begin
          ack_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        ack_d    = '0;
        pg_req_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

`ifdef HBUF_PG_ARB_GNT_CNT_EN
  logic enter_rel;
  assign enter_rel = (state_q == S_REQ) && pg_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt <= '0;
    end else if (enter_rel) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_idx == IDX_W'(i)) gnt_cnt[i*16 +: 16] <= gnt_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`else
  // Counter logic compiled out; gnt_cnt port absent.
`endif

endmodule

// File: tb/tb_hbuf_pg_arb.sv
// Self-checking bench for hbuf_pg_arb: transaction-level reference model plus directed and random traffic.
module tb_hbuf_pg_arb;
  localparam int N  = 4;
  localparam int AW = 28;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_in = '0;
  logic [N-1:0]    optype_in = '0;
  logic [N*AW-1:0] addr_in = '0;
  logic [N-1:0]    ack_out;
  logic            pg_req, pg_optype, pg_ack = 1'b0, busy;
  logic [AW-1:0]   pg_addr;
  logic [IW-1:0]   grant_idx;
`ifdef HBUF_PG_ARB_GNT_CNT_EN
  logic [N*16-1:0] gnt_cnt;
`endif

  hbuf_pg_arb #(.N_REQ(N), .ADDR_W(AW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .optype_in(optype_in), .addr_in(addr_in),
    .ack_out(ack_out), .pg_req(pg_req), .pg_optype(pg_optype), .pg_addr(pg_addr),
    .pg_ack(pg_ack), .busy(busy), .grant_idx(grant_idx)
`ifdef HBUF_PG_ARB_GNT_CNT_EN
    , .gnt_cnt(gnt_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = no grant, 1 = DDR3 request outstanding, 2 = awaiting release.
  int          m_phase = 0, m_grant = N - 1, m_ack = -1, m_win;
  logic        m_req = 1'b0, m_opt = 1'b0;
  logic [AW-1:0] m_addr = '0;
  int          m_cnt [N];
  int          gq[$];
  int          grant_total = 0;
  logic        m_found;

  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_grant = N - 1; m_ack = -1; m_req = 0; m_opt = 0; m_addr = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else if (m_phase == 0) begin
        if (req_in != '0) begin
          m_found = 0; m_win = 0;
          for (int k = 1; k <= N; k++) begin
            if (!m_found && req_in[(m_grant + k) % N]) begin
              m_win = (m_grant + k) % N; m_found = 1;
            end
          end
          m_grant = m_win; m_addr = addr_in[m_win*AW +: AW]; m_opt = optype_in[m_win];
          m_req = 1; m_phase = 1;
          gq.push_back(m_win); grant_total++;
        end
      end else if (m_phase == 1) begin
        if (pg_ack) begin
          m_req = 0; m_ack = m_grant; m_phase = 2;
          m_cnt[m_grant] = (m_cnt[m_grant] + 1) % 65536;
        end
      end else begin
        if (!req_in[m_grant] && !pg_ack) begin
          m_ack = -1; m_phase = 0;
        end
      end
    end
  end

  // Per-cycle compare on the falling edge.
  logic [N-1:0] exp_ack;
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      exp_ack = '0;
      if (m_ack >= 0) exp_ack[m_ack] = 1'b1;
      chk("ack_out", ack_out, exp_ack);
      chk("pg_req", pg_req, m_req);
      chk("pg_optype", pg_optype, m_opt);
      chk("pg_addr", pg_addr, m_addr);
      chk("busy", busy, m_phase != 0);
      chk("grant_idx", grant_idx, m_grant);
      chk("ack_onehot", $countones(ack_out) <= 1, 1);
`ifdef HBUF_PG_ARB_GNT_CNT_EN
      for (int i = 0; i < N; i++) chk("gnt_cnt", gnt_cnt[i*16 +: 16], m_cnt[i]);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 0; req_in = '0; pg_ack = 0;
    tick(1);
    rst_n = 1;
    tick(1);
    gq.delete();
    grant_total = 0;
  endtask

  // Autonomous requesters and DDR3 engine, bounded by max_cyc; stops raising at 'target' grants.
  task automatic run_auto(input int max_cyc, input int target, input logic [N-1:0] en,
                          input int p_raise, input int p_ack, input int p_drop);
    int pend;
    logic [N-1:0] gmask;
    logic done;
    done = 0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      if (grant_total >= target && m_phase == 0 && req_in == '0 && !pg_ack) begin
        done = 1;
      end else begin
        gmask = '0;
        if (m_phase != 0) gmask[m_grant] = 1'b1;
        pend = grant_total + $countones(req_in & ~gmask);
        for (int i = 0; i < N; i++) begin
          if (req_in[i] && ack_out[i]) begin
            if ($urandom_range(99) < p_drop) req_in[i] = 0;
          end else if (!req_in[i] && !ack_out[i] && en[i] && pend < target &&
                       $urandom_range(99) < p_raise) begin
            addr_in[i*AW +: AW] = AW'($urandom);
            optype_in[i] = 1'($urandom);
            req_in[i] = 1; pend++;
          end
        end
        if (pg_req && !pg_ack && $urandom_range(99) < p_ack) pg_ack = 1;
        else if (!pg_req && pg_ack && $urandom_range(99) < p_drop) pg_ack = 0;
        if ($urandom_range(3) == 0) addr_in[$urandom_range(N-1)*AW +: AW] = AW'($urandom);
        tick(1);
      end
    end
    chk("run_auto_done", done, 1);
  endtask

  initial begin
    tick(2);
    chk_on = 1;
    chk("rst_ack", ack_out, 0); chk("rst_pg_req", pg_req, 0); chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 3); chk("rst_addr", pg_addr, 0);
    rst_n = 1;
    tick(1);

    // Single write request from requester 0.
    addr_in[0 +: AW] = 28'h0003000; optype_in = 4'b0001; req_in = 4'b0001;
    tick(1);
    chk("t1_pg_req", pg_req, 1); chk("t1_addr", pg_addr, 28'h0003000);
    chk("t1_opt", pg_optype, 1); chk("t1_grant", grant_idx, 0);
    tick(4);
    pg_ack = 1;
    tick(1);
    chk("t1_ack", ack_out, 4'b0001); chk("t1_pg_req_low", pg_req, 0);
    req_in = '0; pg_ack = 0;
    tick(1);
    chk("t1_ack_fall", ack_out, 0); chk("t1_idle", busy, 0);

    // All four requesting continuously.
    do_reset();
    run_auto(2000, 8, 4'b1111, 100, 50, 50);
    chk("t2_ngrants", gq.size(), 8);
    for (int i = 0; i < 8 && i < gq.size(); i++) chk("t2_order", gq[i], i % 4);

    // Address freeze during S_REQ.
    do_reset();
    addr_in[2*AW +: AW] = 28'h0005000; optype_in = '0; req_in = 4'b0100;
    tick(1);
    chk("t3_grant", grant_idx, 2); chk("t3_addr", pg_addr, 28'h0005000);
    addr_in[2*AW +: AW] = 28'h0006000;
    tick(2);
    chk("t3_addr_frozen", pg_addr, 28'h0005000);
    pg_ack = 1;
    tick(1);
    chk("t3_ack", ack_out, 4'b0100);
    req_in = '0; pg_ack = 0;
    tick(3);
    chk("t3_addr_hold", pg_addr, 28'h0005000);

    // Requester 1 aborts before pg_ack.
    req_in = 4'b0010;
    tick(1);
    chk("t4_grant", grant_idx, 1); chk("t4_pg_req", pg_req, 1);
    req_in = '0;
    tick(3);
    chk("t4_pg_req_held", pg_req, 1); chk("t4_no_ack", ack_out, 0);
    pg_ack = 1;
    tick(1);
    chk("t4_ack", ack_out, 4'b0010);
    tick(1);
    chk("t4_ack_wait", ack_out, 4'b0010);
    pg_ack = 0;
    tick(1);
    chk("t4_ack_fall", ack_out, 0); chk("t4_idle", busy, 0);

    // Reset while in S_REL for requester 3.
    req_in = 4'b1000;
    tick(1);
    chk("t5_grant", grant_idx, 3);
    pg_ack = 1;
    tick(1);
    chk("t5_ack", ack_out, 4'b1000);
    tick(1);
    #1;
    rst_n = 0; req_in = '0; pg_ack = 0;
    #1;
    chk("t5_rst_ack", ack_out, 0); chk("t5_rst_pg_req", pg_req, 0);
    chk("t5_rst_busy", busy, 0); chk("t5_rst_grant", grant_idx, 3);
    tick(1);
    rst_n = 1; req_in = 4'b1001;
    tick(1);
    chk("t5_first_win", grant_idx, 0);
    pg_ack = 1;
    tick(1);
    req_in = 4'b1000; pg_ack = 0;
    tick(2);
    chk("t5_next_win", grant_idx, 3);
    pg_ack = 1;
    tick(1);
    req_in = '0; pg_ack = 0;
    tick(2);

    // Requesters 0 and 2 for six grants.
    do_reset();
    run_auto(3000, 6, 4'b0101, 100, 40, 40);
    chk("t6_ngrants", gq.size(), 6);
    for (int i = 0; i < 6 && i < gq.size(); i++) chk("t6_order", gq[i], (i % 2) * 2);
`ifdef HBUF_PG_ARB_GNT_CNT_EN
    chk("t6_cnt0", gnt_cnt[0 +: 16], 3); chk("t6_cnt1", gnt_cnt[16 +: 16], 0);
    chk("t6_cnt2", gnt_cnt[32 +: 16], 3); chk("t6_cnt3", gnt_cnt[48 +: 16], 0);
`endif

    // Single active requester wraps onto itself.
    do_reset();
    run_auto(2000, 4, 4'b0100, 100, 100, 100);
    chk("t7_ngrants", gq.size(), 4);
    for (int i = 0; i < gq.size(); i++) chk("t7_self", gq[i], 2);

    // Random traffic against the model.
    do_reset();
    run_auto(20000, 400, 4'b1111, 30, 35, 35);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
